// File: rtl/spine_rx_arbiter_pkg.sv
// Shared constants and types for the spine ingress arbiter.
package spine_rx_arbiter_pkg;
    localparam int FLIT_W    = 16;
    localparam int DEST_MSB  = 15;
    localparam int DEST_LSB  = 10;
    localparam int NUM_SPINE = 4;

    typedef enum logic {IDLE, BURST} state_t;

    function automatic logic [2:0] count4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction
endpackage

// File: rtl/spine_rx_arbiter_if.sv
// Spine ingress / NI egress bundle for the arbiter.
interface spine_rx_arbiter_if #(
    parameter int DWIDTH    = 16,
    parameter int NUM_PORTS = 4
);
    logic [NUM_PORTS-1:0][DWIDTH-1:0] sp_in_data;
    logic [NUM_PORTS-1:0]             sp_in_valid;
    logic [NUM_PORTS-1:0]             sp_in_ready;
    logic [DWIDTH-1:0]                out_data;
    logic                             out_valid;
    logic                             out_ready;
    logic [1:0]                       grant_port;
    logic                             busy;
    logic [15:0]                      drop_count;

    modport master (
        output sp_in_data, sp_in_valid, out_ready,
        input  sp_in_ready, out_data, out_valid, grant_port, busy, drop_count
    );
    modport slave (
        input  sp_in_data, sp_in_valid, out_ready,
        output sp_in_ready, out_data, out_valid, grant_port, busy, drop_count
    );
endinterface

// File: rtl/spine_rx_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after start, wrapping mod 4.
module spine_rx_arbiter_rr_pick (
    input  logic [3:0] req,
    input  logic [1:0] start,
    output logic       found,
    output logic [1:0] winner
);
    logic [1:0] idx;

    // Scan from the far end so the nearest request to start is written last.
    always_comb begin
        found  = 1'b0;
        winner = start;
        idx    = start;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end
endmodule

// File: rtl/spine_rx_arbiter.sv
// Four spine ports -> one registered GPU egress, burst round-robin.
// Optional destination filter: define SPINE_DEST_FILTER_EN.
module spine_rx_arbiter
    import spine_rx_arbiter_pkg::*;
#(
    parameter int DWIDTH    = FLIT_W,
    parameter int NUM_PORTS = NUM_SPINE,
    parameter int GPU_ID    = 28,
    parameter int MAX_BURST = 4
) (
    input  logic               ACLK,
    input  logic               ARESETn,
    spine_rx_arbiter_if.slave  bus
);
    logic [DWIDTH-1:0]    fbuf [NUM_PORTS];
    logic [NUM_PORTS-1:0] buf_vld, drain, ready, hs, keep;
    logic [DWIDTH-1:0]    out_q;
    logic                 out_vld_q;
    state_t               state, state_n;
    logic [1:0]           rr_ptr, rr_ptr_n, grant, grant_n, pick_start, pick_w, win;
    logic [3:0]           cnt, cnt_n;
    logic                 lo, pick_found, win_vld;
    logic [15:0]          drop_q;

    assign lo         = !out_vld_q || bus.out_ready;
    assign pick_start = (state == BURST) ? grant + 2'd1 : rr_ptr;

    spine_rx_arbiter_rr_pick u_pick (
        .req    (buf_vld),
        .start  (pick_start),
        .found  (pick_found),
        .winner (pick_w)
    );

    always_comb begin
        state_n  = state;
        rr_ptr_n = rr_ptr;
        grant_n  = grant;
        cnt_n    = cnt;
        win_vld  = 1'b0;
        win      = grant;
        if (lo) begin
            if (state == BURST && buf_vld[grant] && cnt < 4'(MAX_BURST)) begin
                win_vld = 1'b1;
                cnt_n   = cnt + 4'd1;
            end else begin
                // Releasing a burst moves the pointer past the holder before re-arbitrating.
                if (state == BURST) rr_ptr_n = grant + 2'd1;
                if (pick_found) begin
                    win_vld = 1'b1;
                    win     = pick_w;
                    grant_n = pick_w;
                    cnt_n   = 4'd1;
                    state_n = BURST;
                end else begin
                    state_n = IDLE;
                end
            end
        end
    end

    assign drain = win_vld ? (NUM_PORTS'(1) << win) : '0;
    assign ready = ~buf_vld | drain;
    assign hs    = bus.sp_in_valid & ready;

`ifdef SPINE_DEST_FILTER_EN
    localparam logic [5:0] GPU_DEST = 6'(GPU_ID);
    logic [NUM_PORTS-1:0] drops;
    logic [16:0]          drop_sum;
    always_comb begin
        keep = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            keep[i] = hs[i] && (bus.sp_in_data[i][DEST_MSB:DEST_LSB] == GPU_DEST);
    end
    assign drops    = hs & ~keep;
    assign drop_sum = {1'b0, drop_q} + 17'(count4(drops));
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn)         drop_q <= '0;
        else if (drop_sum[16]) drop_q <= 16'hFFFF;
        else                   drop_q <= drop_sum[15:0];
    end
`else
    assign keep   = hs;
    assign drop_q = '0;
`endif

    // A refill wins over a drain, so a port streaming back-to-back stays valid.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int i = 0; i < NUM_PORTS; i++) fbuf[i] <= '0;
            buf_vld <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (keep[i]) begin
                    fbuf[i]    <= bus.sp_in_data[i];
                    buf_vld[i] <= 1'b1;
                end else if (drain[i]) begin
                    buf_vld[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            out_q     <= '0;
            out_vld_q <= 1'b0;
            state     <= IDLE;
            rr_ptr    <= '0;
            grant     <= '0;
            cnt       <= '0;
        end else begin
            if (lo) begin
                out_vld_q <= win_vld;
                if (win_vld) out_q <= fbuf[win];
            end
            state  <= state_n;
            rr_ptr <= rr_ptr_n;
            grant  <= grant_n;
            cnt    <= cnt_n;
        end
    end

    assign bus.sp_in_ready = ready;
    assign bus.out_data    = out_q;
    assign bus.out_valid   = out_vld_q;
    assign bus.grant_port  = grant;
    assign bus.busy        = (state == BURST);
    assign bus.drop_count  = drop_q;
endmodule

// File: tb/tb_spine_rx_arbiter.sv
// Directed bench: vector table for single-port streaming plus corner-case sequences.
module tb_spine_rx_arbiter;
    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    always #5 ACLK = ~ACLK;

    spine_rx_arbiter_if b4 ();
    spine_rx_arbiter_if b2 ();

    spine_rx_arbiter #(.MAX_BURST(4)) u4 (.ACLK(ACLK), .ARESETn(ARESETn), .bus(b4));
    spine_rx_arbiter #(.MAX_BURST(2)) u2 (.ACLK(ACLK), .ARESETn(ARESETn), .bus(b2));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] fl(input logic [5:0] d, input logic [9:0] p);
        return {d, p};
    endfunction

    typedef struct {
        logic [3:0]       vld;
        logic [3:0][15:0] d;
        logic             ev;
        logic [15:0]      ed;
        logic [3:0]       er;
        logic [1:0]       eg;
        logic             eb;
    } vec_t;
    vec_t vq[$];

    task automatic add(input logic [3:0] v, input logic [15:0] d0, input logic [15:0] d2,
                       input logic [15:0] d3, input logic ev, input logic [15:0] ed,
                       input logic [3:0] er, input logic [1:0] eg, input logic eb);
        vec_t t;
        t.vld = v; t.d = '0; t.d[0] = d0; t.d[2] = d2; t.d[3] = d3;
        t.ev = ev; t.ed = ed; t.er = er; t.eg = eg; t.eb = eb;
        vq.push_back(t);
    endtask

    initial begin
        logic [15:0] fa, fb, held;
        logic [15:0] fexp [3];
        logic [15:0] oq [$];
        logic [3:0]  hs2;
        int          seq [4];
        int          pc  [4];
        int          sent, got, k, fn, ep;
        logic        hsp;

        b4.sp_in_data = '0; b4.sp_in_valid = 4'hF; b4.out_ready = 1'b1;
        b2.sp_in_data = '0; b2.sp_in_valid = 4'h0; b2.out_ready = 1'b1;

        // Reset held with all ports requesting
        repeat (2) @(posedge ACLK);
        #1;
        chk("rst_out_valid", 32'(b4.out_valid), 0);
        chk("rst_ready", 32'(b4.sp_in_ready), 32'hF);
        chk("rst_drop", 32'(b4.drop_count), 0);
        chk("rst_grant", 32'(b4.grant_port), 0);
        chk("rst_busy", 32'(b4.busy), 0);
        b4.sp_in_valid = 4'h0;
        @(negedge ACLK);
        ARESETn = 1'b1;

        // Port 2 streams 6 flits; then ports 0 and 3 race with rr_ptr left at 3
        fa = fl(6'd28, 10'h0A0);
        fb = fl(6'd28, 10'h0B0);
        add(4'b0100, 0, fl(28, 1), 0, 0, 0,          4'hF, 0, 0);
        add(4'b0100, 0, fl(28, 2), 0, 0, 0,          4'hF, 0, 0);
        add(4'b0100, 0, fl(28, 3), 0, 1, fl(28, 1),  4'hF, 2, 1);
        add(4'b0100, 0, fl(28, 4), 0, 1, fl(28, 2),  4'hF, 2, 1);
        add(4'b0100, 0, fl(28, 5), 0, 1, fl(28, 3),  4'hF, 2, 1);
        add(4'b0100, 0, fl(28, 6), 0, 1, fl(28, 4),  4'hF, 2, 1);
        add(4'b0000, 0, 0,         0, 1, fl(28, 5),  4'hF, 2, 1);
        add(4'b0000, 0, 0,         0, 1, fl(28, 6),  4'hF, 2, 1);
        add(4'b1001, fa, 0,        fb, 0, 0,         4'hF, 0, 0);
        add(4'b0000, 0, 0,         0, 0, 0,          4'hE, 0, 0);
        add(4'b0000, 0, 0,         0, 1, fb,         4'hF, 3, 1);
        add(4'b0000, 0, 0,         0, 1, fa,         4'hF, 0, 1);
        add(4'b0000, 0, 0,         0, 0, 0,          4'hF, 0, 0);

        foreach (vq[i]) begin
            @(posedge ACLK); #1;
            b4.sp_in_valid = vq[i].vld;
            b4.sp_in_data  = vq[i].d;
            #1;
            chk($sformatf("v%0d_valid", i), 32'(b4.out_valid), 32'(vq[i].ev));
            chk($sformatf("v%0d_ready", i), 32'(b4.sp_in_ready), 32'(vq[i].er));
            chk($sformatf("v%0d_busy", i), 32'(b4.busy), 32'(vq[i].eb));
            if (vq[i].ev) begin
                chk($sformatf("v%0d_data", i), 32'(b4.out_data), 32'(vq[i].ed));
                chk($sformatf("v%0d_grant", i), 32'(b4.grant_port), 32'(vq[i].eg));
            end
        end

        // Contention, MAX_BURST=2: every port always offering a flit
        for (int i = 0; i < 4; i++) begin seq[i] = 0; pc[i] = 0; end
        hs2 = '0; got = 0;
        for (int c = 0; c < 60 && got < 16; c++) begin
            @(posedge ACLK); #1;
            for (int i = 0; i < 4; i++) begin
                if (hs2[i]) seq[i]++;
                b2.sp_in_data[i] = fl(6'd28, {i[1:0], seq[i][7:0]});
            end
            b2.sp_in_valid = 4'hF;
            #1;
            hs2 = b2.sp_in_valid & b2.sp_in_ready;
            if (b2.out_valid) begin
                ep = (got / 2) % 4;
                chk($sformatf("ctn%0d_port", got), 32'(b2.out_data[9:8]), 32'(ep));
                chk($sformatf("ctn%0d_seq", got), 32'(b2.out_data[7:0]), 32'(pc[ep]));
                pc[ep]++;
                got++;
            end
        end
        chk("ctn_count", 32'(got), 16);
        b2.sp_in_valid = 4'h0;

        // Backpressure: out_ready low for 5 cycles mid-stream on port 1
        sent = 0; got = 0; hsp = 1'b0; held = '0;
        for (int c = 0; c < 40; c++) begin
            @(posedge ACLK); #1;
            if (hsp) sent++;
            b4.sp_in_valid = (sent < 8) ? 4'b0010 : 4'b0000;
            b4.sp_in_data  = '0;
            b4.sp_in_data[1] = fl(6'd28, 10'h100 + 10'(sent));
            b4.out_ready = !(c >= 5 && c <= 9);
            #1;
            hsp = b4.sp_in_valid[1] & b4.sp_in_ready[1];
            if (c == 5) begin
                held = b4.out_data;
                chk("bp_valid_at_stall", 32'(b4.out_valid), 1);
            end
            if (c > 5 && c <= 9) begin
                chk($sformatf("bp%0d_hold", c), 32'(b4.out_data), 32'(held));
                chk($sformatf("bp%0d_ready", c), 32'(b4.sp_in_ready[1]), 0);
            end
            if (b4.out_valid && b4.out_ready) begin
                chk($sformatf("bp_out%0d", got), 32'(b4.out_data), 32'(fl(6'd28, 10'h100 + 10'(got))));
                got++;
            end
        end
        chk("bp_count", 32'(got), 8);
        b4.out_ready = 1'b1;
        b4.sp_in_valid = 4'h0;

        // Destination filter on port 1: dests 27, 28, 5
`ifdef SPINE_DEST_FILTER_EN
        fexp[0] = fl(6'd28, 10'd2); fexp[1] = '0; fexp[2] = '0; fn = 1;
`else
        fexp[0] = fl(6'd27, 10'd1); fexp[1] = fl(6'd28, 10'd2); fexp[2] = fl(6'd5, 10'd3); fn = 3;
`endif
        k = 0; got = 0; hsp = 1'b0;
        for (int c = 0; c < 14; c++) begin
            @(posedge ACLK); #1;
            if (hsp) k++;
            b4.sp_in_data = '0;
            case (k)
                0:       b4.sp_in_data[1] = fl(6'd27, 10'd1);
                1:       b4.sp_in_data[1] = fl(6'd28, 10'd2);
                default: b4.sp_in_data[1] = fl(6'd5,  10'd3);
            endcase
            b4.sp_in_valid = (k < 3) ? 4'b0010 : 4'b0000;
            #1;
            hsp = b4.sp_in_valid[1] & b4.sp_in_ready[1];
            if (b4.out_valid) begin
                if (got < fn) chk($sformatf("flt_out%0d", got), 32'(b4.out_data), 32'(fexp[got]));
                got++;
            end
        end
        chk("flt_count", 32'(got), 32'(fn));
`ifdef SPINE_DEST_FILTER_EN
        chk("flt_drop", 32'(b4.drop_count), 2);
`else
        chk("flt_drop", 32'(b4.drop_count), 0);
`endif

        // Async reset mid-burst, then port 0 and port 3 compete
        sent = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge ACLK); #1;
            b4.sp_in_valid = 4'b0100;
            b4.sp_in_data  = '0;
            b4.sp_in_data[2] = fl(6'd28, 10'h200 + 10'(c));
        end
        @(posedge ACLK); #2;
        chk("ar_pre_valid", 32'(b4.out_valid), 1);
        chk("ar_pre_busy", 32'(b4.busy), 1);
        ARESETn = 1'b0;
        #1;
        chk("ar_valid", 32'(b4.out_valid), 0);
        chk("ar_busy", 32'(b4.busy), 0);
        chk("ar_ready", 32'(b4.sp_in_ready), 32'hF);
        b4.sp_in_valid = 4'h0;
        @(posedge ACLK); #2;
        ARESETn = 1'b1;
        @(posedge ACLK); #1;
        b4.sp_in_data = '0;
        b4.sp_in_data[0] = fl(6'd28, 10'h055);
        b4.sp_in_data[3] = fl(6'd28, 10'h066);
        b4.sp_in_valid = 4'b1001;
        for (int c = 0; c < 8; c++) begin
            @(posedge ACLK); #1;
            b4.sp_in_valid = 4'h0;
            #1;
            if (b4.out_valid) oq.push_back(b4.out_data);
        end
        chk("ar_count", 32'(oq.size()), 2);
        if (oq.size() >= 2) begin
            chk("ar_first", 32'(oq[0]), 32'(fl(6'd28, 10'h055)));
            chk("ar_second", 32'(oq[1]), 32'(fl(6'd28, 10'h066)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
